// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: one round per clock through a shared round datapath.
// Define AES_ENC_KEY_LATCH_EN to capture the key on acceptance instead of requiring it held.
module aes_encrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] LAST = 4'(Nr);
  localparam int         RKW  = 128 * (Nr + 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      b  = gmul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte 4*c+r holds row r, column c; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [RKW-1:0] key_expand(input logic [N-1:0] k);
    logic [31:0]    w [4*(Nr+1)];
    logic [31:0]    t;
    logic [7:0]     rc;
    logic [RKW-1:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4 * (Nr + 1); i++) begin
      if (i < Nk) begin
        w[i] = k[N-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
      r[RKW-1-32*i -: 32] = w[i];
    end
    return r;
  endfunction

  logic [1:0]     fsm;
  logic [3:0]     round;
  logic [127:0]   state;
  logic [N-1:0]   key_src;
  logic [RKW-1:0] rks;
  logic [127:0]   rk_cur;
  logic [127:0]   sr;
  logic [127:0]   nxt;
  logic           accept;

`ifdef AES_ENC_KEY_LATCH_EN
  logic [N-1:0] key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       key_q <= '0;
    else if (accept) key_q <= key;
  end

  assign key_src = key_q;
`else
  assign key_src = key;
`endif

  assign in_ready = ~reset & ((fsm == IDLE) | ((fsm == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  assign rks    = key_expand(key_src);
  assign rk_cur = rks[RKW-1-128*int'(round) -: 128];
  assign sr     = shift_rows(sub_bytes(state));
  // Final round skips MixColumns
  assign nxt    = ((round == LAST) ? sr : mix_columns(sr)) ^ rk_cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      round     <= 4'd0;
      state     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        RUN: begin
          state <= nxt;
          if (round == LAST) begin
            out       <= nxt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fsm       <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: ;
      endcase
      // Round key 0 is the leading 128 key bits, so the live key serves the accept cycle
      if (accept) begin
        state <= in ^ key[N-1 -: 128];
        round <= 4'd1;
        busy  <= 1'b1;
        fsm   <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter with AES-128, -192 and -256 instances sharing clock and reset.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   iv;
  logic [2:0]   ordy;
  logic [2:0][127:0] pt;
  logic [2:0][255:0] ky;

  wire          ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  wire [127:0]  ct0, ct1, ct2;
  wire [2:0]    ir = {ir2, ir1, ir0};
  wire [2:0]    ov = {ov2, ov1, ov0};
  wire [2:0]    bz = {bz2, bz1, bz0};
  wire [127:0]  ct [3];

  assign ct[0] = ct0;
  assign ct[1] = ct1;
  assign ct[2] = ct2;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_B = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] CT_C  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_D = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_D  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encrypt_iter #(.N(128), .Nr(10), .Nk(4)) dut (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir0), .in(pt[0]),
    .key(ky[0][255 -: 128]), .out_valid(ov0), .out_ready(ordy[0]), .out(ct0), .busy(bz0)
  );

  aes_encrypt_iter #(.N(192), .Nr(12), .Nk(6)) dut192 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1), .in(pt[1]),
    .key(ky[1][255 -: 192]), .out_valid(ov1), .out_ready(ordy[1]), .out(ct1), .busy(bz1)
  );

  aes_encrypt_iter #(.N(256), .Nr(14), .Nk(8)) dut256 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir2), .in(pt[2]),
    .key(ky[2]), .out_valid(ov2), .out_ready(ordy[2]), .out(ct2), .busy(bz2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Offer one block and return at the negedge following its acceptance edge
  task automatic send(input int d, input logic [127:0] p, input logic [255:0] k);
    @(negedge clk);
    pt[d] = p;
    ky[d] = k;
    iv[d] = 1'b1;
    check("in_ready_idle", 256'(ir[d]), 256'(1));
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (ov[d] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
`ifdef AES_ENC_KEY_LATCH_EN
      if (d == 0) ky[0] = {$urandom, $urandom, $urandom, $urandom, 128'h0};
`endif
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad;
    reset = 1'b1;
    iv    = '0;
    ordy  = '1;
    pt    = '0;
    ky    = '0;

    #2;
    check("rst_in_ready", 256'(ir), 256'(0));
    check("rst_out_valid", 256'(ov), 256'(0));
    check("rst_busy", 256'(bz), 256'(0));
    check("rst_out", 256'(ct[0]), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", 256'(ir), 256'(3'b111));

    // AES-128 known answer with latency
    send(0, PT_A, KEY_A);
    check("busy_run", 256'(bz[0]), 256'(1));
    check("in_ready_run", 256'(ir[0]), 256'(0));
    wait_out(0, lat);
    check("lat128", 256'(lat), 256'(10));
    check("ct128", 256'(ct[0]), 256'(CT_A));
    check("busy_done", 256'(bz[0]), 256'(0));
    @(posedge clk);
    @(negedge clk);
    check("ov_after_hs", 256'(ov[0]), 256'(0));
    check("out_held", 256'(ct[0]), 256'(CT_A));

    send(1, PT_B, KEY_C);
    wait_out(1, lat);
    check("lat192", 256'(lat), 256'(12));
    check("ct192", 256'(ct[1]), 256'(CT_C));

    send(2, PT_B, KEY_D);
    wait_out(2, lat);
    check("lat256", 256'(lat), 256'(14));
    check("ct256", 256'(ct[2]), 256'(CT_D));

    // Backpressure: sink stalls for 20 cycles
    ordy[0] = 1'b0;
    send(0, PT_B, KEY_B);
    wait_out(0, lat);
    check("lat_bp", 256'(lat), 256'(10));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov[0] !== 1'b1 || ct[0] !== CT_B || ir[0] !== 1'b0) bad++;
    end
    check("bp_stable", 256'(bad), 256'(0));
    ordy[0] = 1'b1;
    #1;
    check("bp_in_ready", 256'(ir[0]), 256'(1));
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ov", 256'(ov[0]), 256'(0));
    check("bp_release_out", 256'(ct[0]), 256'(CT_B));
    check("bp_idle_busy", 256'(bz[0]), 256'(0));

    // Back-to-back: second block accepted on the first output handshake
    send(0, PT_A, KEY_A);
    wait_out(0, lat);
    check("b2b_lat1", 256'(lat), 256'(10));
    check("b2b_ct1", 256'(ct[0]), 256'(CT_A));
    pt[0] = PT_B;
    ky[0] = KEY_B;
    iv[0] = 1'b1;
    #1;
    check("b2b_in_ready", 256'(ir[0]), 256'(1));
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    check("b2b_ov_drop", 256'(ov[0]), 256'(0));
    check("b2b_busy", 256'(bz[0]), 256'(1));
    wait_out(0, lat);
    check("b2b_spacing", 256'(lat + 1), 256'(11));
    check("b2b_ct2", 256'(ct[0]), 256'(CT_B));
    @(posedge clk);

    // Reset pulse mid-run aborts the block
    send(0, PT_A, KEY_A);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 256'(bz[0]), 256'(0));
    check("abort_ov", 256'(ov[0]), 256'(0));
    check("abort_out", 256'(ct[0]), 256'(0));
    check("abort_in_ready", 256'(ir[0]), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) bad++;
    end
    check("abort_no_ov", 256'(bad), 256'(0));
    send(0, PT_A, KEY_A);
    wait_out(0, lat);
    check("post_abort_lat", 256'(lat), 256'(10));
    check("post_abort_ct", 256'(ct[0]), 256'(CT_A));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
